// File: rtl/hazard_pkg.sv
// Shared constants for the hazard sequencer: FSM state codes, branch-compare
// forward selects and the Control-unit branch encoding.
package hazard_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_STALL = 2'd1;
    localparam state_t ST_MWAIT = 2'd2;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b10;
    localparam logic [1:0] BR_BNE  = 2'b11;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classifier: how many bubbles the ID instruction needs
// (0, 1 or 2) and where the ID-stage branch comparator takes its operands.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rt,
    input  logic [1:0]       branch,
    input  logic             idex_regwrite,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             exmem_regwrite,
    input  logic             exmem_memread,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             memwb_regwrite,
    input  logic [REG_W-1:0] memwb_rd,
    output logic [1:0]       depth,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);
    import hazard_pkg::*;

    logic is_br, hit_ex, hit_mem;

    // $0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic reads(input logic [REG_W-1:0] rd);
        return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

    // The youngest ALU result (EX/MEM) is the most recent value and wins.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] r);
        if (exmem_regwrite && !exmem_memread && (exmem_rd != '0) && (exmem_rd == r))
            return FWD_EXMEM;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    // Bubble depth: a branch behind a load needs the value two stages later.
    always_comb begin
        is_br   = (branch != BR_NONE);
        hit_ex  = reads(idex_rd);
        hit_mem = reads(exmem_rd);
        depth   = 2'd0;
        if (is_br && idex_memread && hit_ex)
            depth = 2'd2;
        else if ((idex_memread && hit_ex) ||
                 (is_br && idex_regwrite && hit_ex) ||
                 (is_br && exmem_memread && hit_mem))
            depth = 2'd1;
    end

    // Branch operand forward selects (rs -> a, rt -> b).
    always_comb begin
        fwd_a = fwd_sel(rs);
        fwd_b = fwd_sel(rt);
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush sequencer for the 5-stage core. Holds PC and IF/ID and
// bubbles ID/EX on data hazards, flushes IF/ID on taken control transfers and
// freezes the pipe while data memory is busy.
// Optional feature: define HAZARD_PERF_EN to build saturating perf counters;
// otherwise the perf_* outputs are constant zero.
module hazard_sequencer #(
    parameter int REG_W  = 5,
    parameter int PERF_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_W-1:0]  ifid_rs,
    input  logic [REG_W-1:0]  ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic [1:0]        ifid_branch,
    input  logic              ifid_jump,
    input  logic              branch_taken,
    input  logic              idex_regwrite,
    input  logic              idex_memread,
    input  logic [REG_W-1:0]  idex_rd,
    input  logic              exmem_regwrite,
    input  logic              exmem_memread,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic              memwb_regwrite,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush,
    output logic [PERF_W-1:0] perf_wait
);
    import hazard_pkg::*;

    state_t     state, nxt_state;
    state_t     ret_state, nxt_ret;
    logic [1:0] depth, det_fa, det_fb;
    logic       mem_busy, redirect;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .rs             (ifid_rs),
        .rt             (ifid_rt),
        .uses_rt        (ifid_uses_rt),
        .branch         (ifid_branch),
        .idex_regwrite  (idex_regwrite),
        .idex_memread   (idex_memread),
        .idex_rd        (idex_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_memread  (exmem_memread),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .depth          (depth),
        .fwd_a          (det_fa),
        .fwd_b          (det_fb)
    );

    // Output/next-state decode; stall outputs in RUN are Mealy on depth.
    always_comb begin
        mem_busy    = dmem_req && !dmem_ready;
        redirect    = ifid_jump || ((ifid_branch != BR_NONE) && branch_taken);
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b1;
        nxt_state   = state;
        nxt_ret     = ret_state;
        fwd_a       = det_fa;
        fwd_b       = det_fb;
        case (state)
            ST_RUN: begin
                if (mem_busy) begin
                    {pc_write, ifid_write, pipe_en} = 3'b000;
                    nxt_state = ST_MWAIT;
                    nxt_ret   = ST_RUN;
                end else if (depth != 2'd0) begin
                    {pc_write, ifid_write, idex_bubble} = 3'b001;
                    if (depth == 2'd2) nxt_state = ST_STALL;
                end else if (redirect) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_STALL: begin
                // Second bubble of a load->branch stall; branch outcome not valid yet.
                if (mem_busy) begin
                    {pc_write, ifid_write, pipe_en} = 3'b000;
                    nxt_state = ST_MWAIT;
                    nxt_ret   = ST_STALL;
                end else begin
                    {pc_write, ifid_write, idex_bubble} = 3'b001;
                    nxt_state = ST_RUN;
                end
            end
            ST_MWAIT: begin
                {pc_write, ifid_write, pipe_en} = 3'b000;
                if (dmem_ready) nxt_state = ret_state;
            end
            default: nxt_state = ST_RUN;
        endcase
        if (reset) begin
            {pc_write, ifid_write, pipe_en} = 3'b000;
            {ifid_flush, idex_bubble}       = 2'b11;
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
        end
    end

    // State and saved return state (the pending stall survives a memory wait).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
        end else begin
            state     <= nxt_state;
            ret_state <= nxt_ret;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters: bubble cycles, flush pulses, wait cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_wait  <= '0;
        end else begin
            if (idex_bubble && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
            if (ifid_flush && (perf_flush != '1))  perf_flush <= perf_flush + 1'b1;
            if ((state == ST_MWAIT) && (perf_wait != '1)) perf_wait <= perf_wait + 1'b1;
        end
    end
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
    assign perf_wait  = '0;
`endif

endmodule
